ram_stream_ctrl: RTL and testbench
==================================

RAM_STREAM_CTRL -- requirements
Module: ram_stream_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, data word width (matches RAM word).
REQ-002 Parameter ADDR_W, default 6, RAM address width (64 locations).
REQ-003 clk  input  1  single clock; all state on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start_wr  input  1  one-cycle request: stream s_data into RAM.
REQ-006 start_rd  input  1  one-cycle request: stream RAM contents out on m_data.
REQ-007 base_addr  input  ADDR_W  first RAM address of the transfer, sampled at start.
REQ-008 length  input  ADDR_W+1  word count 0..64, sampled at start.
REQ-009 s_data / s_valid / s_ready  in/in/out  DATA_W/1/1  write-stream input, valid/ready handshake.
REQ-010 m_data / m_valid / m_ready  out/out/in  DATA_W/1/1  read-stream output, valid/ready handshake.
REQ-011 busy  output  1  high in WRITE or READ.
REQ-012 done  output  1  one-cycle pulse at end of each accepted transfer.
REQ-013 ram_address / ram_in / ram_load  out/out/out  ADDR_W/DATA_W/1  drive RAM write port and address.
REQ-014 ram_out  input  DATA_W  RAM combinational read data for ram_address.
REQ-015 checksum  output  DATA_W  transfer checksum (see Configuration).

Function
REQ-016 FSM states IDLE, WRITE, READ, DONE; IDLE after reset.
REQ-017 IDLE: start_wr -> WRITE; else start_rd -> READ; both high same cycle -> WRITE (write wins).
REQ-018 On start, capture addr=base_addr, cnt=min(length,64); length 0 -> DONE directly, no RAM access, no handshake.
REQ-019 start_wr/start_rd outside IDLE ignored, no effect on current transfer.
REQ-020 WRITE: s_ready=1; beat = s_valid&&s_ready; on beat, same cycle ram_load=1, ram_address=addr, ram_in=s_data; RAM captures at next posedge.
REQ-021 READ: ram_address=addr, m_data=ram_out, m_valid=1; beat = m_valid&&m_ready; addr and m_data stable while m_ready low.
REQ-022 Each beat: addr<=addr+1 modulo 2^ADDR_W (63 wraps to 0), cnt<=cnt-1; beat with cnt==1 -> DONE.
REQ-023 DONE lasts exactly one cycle, done=1, then IDLE; a start seen in DONE is ignored.
REQ-024 Outside WRITE: s_ready=0, ram_load=0. Outside READ: m_valid=0, m_data=0. ram_address=addr in WRITE/READ, 0 otherwise; ram_in=0 when ram_load=0.
REQ-025 No bubble: back-to-back beats sustain one word per cycle.

Reset
REQ-026 rst_n low asynchronously forces IDLE, addr=0, cnt=0, checksum=0; all outputs 0 immediately, including ram_load (no partial write).
REQ-027 Reset mid-transfer abandons it; no done pulse; RAM words already written remain.

Configuration
REQ-028 Macro RAM_STREAM_CHECKSUM_EN defined: checksum cleared on accepted start, adds each beat's word modulo 2^DATA_W, holds final value from DONE until next start.
REQ-029 Macro undefined: checksum tied to 0, no accumulator logic; all other behaviour identical.

Structure
REQ-030 Package ram_stream_pkg holds DATA_W/ADDR_W defaults, MAX_LEN=64 and the state enum typedef.
REQ-031 One sub-module ram_stream_addr_gen (load base/count, step, wrap, last flag); FSM and handshakes in ram_stream_ctrl.

Verification
REQ-032 start_wr, base=10, length=4, s_data 0xA000..0xA003 valid every cycle -> RAM[10..13]=0xA000..0xA003, done pulse 1 cycle after 4th beat, checksum 0x8006 if enabled.
REQ-033 start_rd, base=62, length=4, m_ready toggling 1/0 -> m_data in order from RAM[62],[63],[0],[1], no repeat/skip, data stable while stalled.
REQ-034 start_wr and start_rd same cycle, length=2 -> WRITE taken, m_valid never high.
REQ-035 length=0 and length=100 -> done the cycle after start with zero beats; 100 clamps to 64 beats.
REQ-036 rst_n low after 2nd of 5 write beats -> ram_load 0 immediately, IDLE, no done, RAM holds only first 2 words.

Source files
------------

// File: rtl/ram_stream_pkg.sv
// ram_stream_pkg
//   Shared definitions for the RAM stream controller:
//   - default data / address widths
//   - MAX_LEN, the largest transfer the default configuration can address
//   - the controller state enum
package ram_stream_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 6;
    localparam int MAX_LEN    = 1 << DEF_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ram_stream_addr_gen.sv
// ram_stream_addr_gen
//   Address / word-count generator for one streaming transfer.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     load        capture base and count (takes priority over step)
//     base        first address of the transfer
//     count       number of words (already clamped by the caller)
//     step        one beat completed: advance address, decrement count
//     addr        current RAM address (wraps modulo 2^ADDR_W)
//     cnt         words still to transfer
//     last        the current beat is the final one (cnt == 1)
module ram_stream_addr_gen #(
    parameter int ADDR_W = ram_stream_pkg::DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W:0]   cnt,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q,  cnt_d;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load) begin
            addr_d = base;
            cnt_d  = count;
        end else if (step) begin
            // Natural overflow of the ADDR_W-bit adder gives the wrap to 0.
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr = addr_q;
    assign cnt  = cnt_q;
    assign last = (cnt_q == {{ADDR_W{1'b0}}, 1'b1});

endmodule

// File: rtl/ram_stream_ctrl.sv
// ram_stream_ctrl
//   Streams words from s_* into a single-port RAM, or from the RAM out on m_*.
//   Optional feature macro: RAM_STREAM_CHECKSUM_EN (running sum of the words
//   of each transfer on checksum; tied to 0 when undefined).
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     start_wr, start_rd    one-cycle start requests (write wins if both)
//     base_addr, length     transfer start address and word count (0..64,
//                           larger values clamp to 64), sampled at start
//     s_data/s_valid/s_ready  write stream in
//     m_data/m_valid/m_ready  read stream out
//     busy, done            transfer active / one-cycle end pulse
//     ram_address/ram_in/ram_load  RAM port; ram_out is combinational read data
//     checksum              transfer checksum
//     dbg_state             current FSM state (ram_stream_pkg::state_e encoding)
//
//   Handshake: a beat happens in a cycle where valid && ready are both high at
//   the rising edge. The producer holds data stable while valid is high and
//   ready is low; s_ready is high for the whole WRITE state and m_valid is high
//   for the whole READ state, so a beat can occur on every cycle.
module ram_stream_ctrl
    import ram_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_wr,
    input  logic              start_rd,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out,
    output logic [DATA_W-1:0] checksum,
    output logic [1:0]        dbg_state
);

    // Largest transfer: one pass over the whole RAM.
    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_e state_q, state_d;

    logic              load;
    logic              step;
    logic [ADDR_W:0]   len_c;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   cnt;
    logic              last;

    assign len_c = (length > LEN_MAX) ? LEN_MAX : length;

    ram_stream_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .base  (base_addr),
        .count (len_c),
        .step  (step),
        .addr  (addr),
        .cnt   (cnt),
        .last  (last)
    );

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        step        = 1'b0;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        m_data      = '0;
        ram_load    = 1'b0;
        ram_in      = '0;
        ram_address = '0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_wr || start_rd) begin
                    load = 1'b1;
                    if (len_c == '0) begin
                        // Empty transfer: finish without touching the RAM.
                        state_d = ST_DONE;
                    end else if (start_wr) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                busy        = 1'b1;
                s_ready     = 1'b1;
                ram_address = addr;
                if (s_valid) begin
                    ram_load = 1'b1;
                    ram_in   = s_data;
                    step     = 1'b1;
                    if (last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                busy        = 1'b1;
                m_valid     = 1'b1;
                ram_address = addr;
                // Address only moves on a beat, so m_data holds while stalled.
                m_data      = ram_out;
                if (m_ready) begin
                    step = 1'b1;
                    if (last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign dbg_state = state_q;

`ifdef RAM_STREAM_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [DATA_W-1:0] beat_data;

    assign beat_data = (state_q == ST_READ) ? ram_out : s_data;

    always_comb begin
        csum_d = csum_q;
        if (load) begin
            csum_d = '0;
        end else if (step) begin
            csum_d = csum_q + beat_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// tb_ram_stream_ctrl
//   Bench for ram_stream_ctrl with a behavioural 64x16 RAM attached.
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
//   Build with RAM_STREAM_CHECKSUM_EN defined to also cover the checksum.
module tb_ram_stream_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst_n;
    logic              start_wr;
    logic              start_rd;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_in;
    logic              ram_load;
    logic [DATA_W-1:0] ram_out;
    logic [DATA_W-1:0] checksum;
    logic [1:0]        dbg_state;

    logic [DATA_W-1:0] mem [64];

    // Expected RAM writes {address, data} and expected read words.
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0]        rd_exp_q[$];

    int pass_cnt;
    int total_cnt;

    ram_stream_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_wr    (start_wr),
        .start_rd    (start_rd),
        .base_addr   (base_addr),
        .length      (length),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .busy        (busy),
        .done        (done),
        .ram_address (ram_address),
        .ram_in      (ram_in),
        .ram_load    (ram_load),
        .ram_out     (ram_out),
        .checksum    (checksum),
        .dbg_state   (dbg_state)
    );

    // clock / RAM model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_in;
    end
    assign ram_out = mem[ram_address];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic test_reset();
        rst_n = 1'b0; start_wr = 0; start_rd = 0; base_addr = '0; length = '0;
        s_data = '0; s_valid = 0; m_ready = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        total_cnt++;
        if ({busy, done, s_ready, m_valid, ram_load} !== 5'b0)
            $display("FAIL reset_ctl: got %b want 00000", {busy, done, s_ready, m_valid, ram_load});
        else pass_cnt++;
        total_cnt++;
        if ({m_data, ram_in, checksum} !== 48'h0)
            $display("FAIL reset_data: got %h want 0", {m_data, ram_in, checksum});
        else pass_cnt++;
        total_cnt++;
        if ({ram_address, dbg_state} !== 8'h0)
            $display("FAIL reset_addr_state: got %h want 0", {ram_address, dbg_state});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Write stream of min(len,64) words d0, d0+1, ... from base.
    // also_rd: raise start_rd with start_wr. poke: start_rd during beat 1 and
    // start_wr in the DONE cycle, both of which must be ignored.
    task automatic test_write_stream(input string name, input logic [5:0] base,
                                     input logic [6:0] len, input logic [15:0] d0,
                                     input bit also_rd, input bit poke);
        int n;
        logic [5:0]  a;
        logic [15:0] d;
        logic [15:0] sum;
        logic [15:0] exp_cs;
        logic [21:0] got;
        logic [21:0] want;
        n = (len > 7'd64) ? 64 : int'(len);
        a = base;
        sum = '0;
        @(negedge clk);
        start_wr = 1'b1; start_rd = also_rd; base_addr = base; length = len;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start_wr = 1'b0;
            start_rd = poke && (i == 1);
            d = d0 + 16'(i);
            s_valid = 1'b1;
            s_data = d;
            exp_q.push_back({a, d});
            sum = sum + d;
            a = a + 1'b1;
            #1;
            total_cnt++;
            if ({ram_load, s_ready, busy, m_valid} !== 4'b1110)
                $display("FAIL %s_beat%0d_ctl: got %b want 1110", name, i, {ram_load, s_ready, busy, m_valid});
            else pass_cnt++;
            got = {ram_address, ram_in};
            want = exp_q.pop_front();
            total_cnt++;
            if (got !== want)
                $display("FAIL %s_beat%0d_wr: got %h want %h", name, i, got, want);
            else pass_cnt++;
        end
`ifdef RAM_STREAM_CHECKSUM_EN
        exp_cs = sum;
`else
        exp_cs = '0;
`endif
        @(negedge clk);
        s_valid = 1'b0; s_data = '0; start_rd = 1'b0; start_wr = poke;
        #1;
        total_cnt++;
        if ({done, busy, ram_load, s_ready} !== 4'b1000)
            $display("FAIL %s_done: got %b want 1000", name, {done, busy, ram_load, s_ready});
        else pass_cnt++;
        total_cnt++;
        if (checksum !== exp_cs)
            $display("FAIL %s_checksum: got %h want %h", name, checksum, exp_cs);
        else pass_cnt++;
        @(negedge clk);
        start_wr = 1'b0;
        #1;
        total_cnt++;
        if ({done, busy, dbg_state} !== 4'b0000)
            $display("FAIL %s_idle: got %b want 0000", name, {done, busy, dbg_state});
        else pass_cnt++;
        total_cnt++;
        if (checksum !== exp_cs)
            $display("FAIL %s_checksum_hold: got %h want %h", name, checksum, exp_cs);
        else pass_cnt++;
        for (int i = 0; i < n; i++) begin
            a = base + 6'(i);
            d = d0 + 16'(i);
            total_cnt++;
            if (mem[a] !== d)
                $display("FAIL %s_ram[%0d]: got %h want %h", name, a, mem[a], d);
            else pass_cnt++;
        end
    endtask

    // Read RAM[62],[63],[0],[1] with m_ready toggling 0/1, starting stalled.
    task automatic test_read_wrap();
        bit          finished;
        logic [15:0] sum;
        logic [15:0] exp_cs;
        test_write_stream("rd_prep", 6'd62, 7'd4, 16'h5A00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) rd_exp_q.push_back(16'h5A00 + 16'(i));
        finished = 1'b0;
        sum = '0;
        @(negedge clk);
        start_rd = 1'b1; base_addr = 6'd62; length = 7'd4;
        for (int cyc = 0; cyc < 30 && !finished; cyc++) begin
            @(negedge clk);
            start_rd = 1'b0;
            m_ready = (cyc % 2) == 1;
            #1;
            if (done) begin
                finished = 1'b1;
                total_cnt++;
                if (rd_exp_q.size() != 0)
                    $display("FAIL rd_count: got %0d left want 0", rd_exp_q.size());
                else pass_cnt++;
`ifdef RAM_STREAM_CHECKSUM_EN
                exp_cs = sum;
`else
                exp_cs = '0;
`endif
                total_cnt++;
                if (checksum !== exp_cs)
                    $display("FAIL rd_checksum: got %h want %h", checksum, exp_cs);
                else pass_cnt++;
            end else begin
                total_cnt++;
                if ({m_valid, busy, s_ready} !== 3'b110)
                    $display("FAIL rd_cyc%0d_ctl: got %b want 110", cyc, {m_valid, busy, s_ready});
                else pass_cnt++;
                total_cnt++;
                if (rd_exp_q.size() == 0)
                    $display("FAIL rd_cyc%0d_extra: got valid beat want done", cyc);
                else if (m_data !== rd_exp_q[0])
                    $display("FAIL rd_cyc%0d_data: got %h want %h", cyc, m_data, rd_exp_q[0]);
                else pass_cnt++;
                if (m_ready && rd_exp_q.size() != 0) begin
                    sum = sum + rd_exp_q[0];
                    void'(rd_exp_q.pop_front());
                end
            end
        end
        m_ready = 1'b0;
        total_cnt++;
        if (!finished)
            $display("FAIL rd_timeout: got no done want done within 30 cycles");
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if ({done, m_valid, m_data} !== 18'h0)
            $display("FAIL rd_after: got %h want 0", {done, m_valid, m_data});
        else pass_cnt++;
    endtask

    // Reset during the 3rd of 5 write beats.
    task automatic test_reset_mid();
        logic [15:0] want;
        @(negedge clk);
        start_wr = 1'b1; base_addr = 6'd30; length = 7'd5;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start_wr = 1'b0; s_valid = 1'b1; s_data = 16'hC000 + 16'(i);
        end
        @(negedge clk);
        s_data = 16'hC002;
        #1;
        total_cnt++;
        if (ram_load !== 1'b1)
            $display("FAIL rstmid_pre_load: got %b want 1", ram_load);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({ram_load, s_ready, busy, done, dbg_state} !== 6'b0)
            $display("FAIL rstmid_async: got %b want 000000", {ram_load, s_ready, busy, done, dbg_state});
        else pass_cnt++;
        total_cnt++;
        if ({ram_in, ram_address, checksum} !== 38'h0)
            $display("FAIL rstmid_outs: got %h want 0", {ram_in, ram_address, checksum});
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) begin
                s_valid = 1'b0;
                rst_n = 1'b1;
            end
            #1;
            total_cnt++;
            if ({done, busy} !== 2'b00)
                $display("FAIL rstmid_nodone%0d: got %b want 00", i, {done, busy});
            else pass_cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            // Words 30,31 rewritten; 32..34 keep the clamp-test data.
            want = (i < 2) ? 16'hC000 + 16'(i) : 16'h1000 + 16'(30 + i);
            total_cnt++;
            if (mem[30 + i] !== want)
                $display("FAIL rstmid_ram[%0d]: got %h want %h", 30 + i, mem[30 + i], want);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_write_stream("wr_basic", 6'd10, 7'd4, 16'hA000, 1'b0, 1'b0);
        test_write_stream("len_zero", 6'd5, 7'd0, 16'hEE00, 1'b0, 1'b0);
        test_write_stream("len_clamp", 6'd0, 7'd100, 16'h1000, 1'b0, 1'b1);
        test_read_wrap();
        test_write_stream("both_start", 6'd20, 7'd2, 16'hB000, 1'b1, 1'b1);
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
